// File: rtl/sram_rw_masked_ext_if.sv
// rtl/sram_rw_masked_ext_if.sv - RW0 access port bundle for the masked single-port SRAM
interface sram_rw_masked_ext_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 64,
    parameter int MASK_GRAN  = 8
);
    localparam int LANES = DATA_WIDTH / MASK_GRAN;

    logic [ADDR_WIDTH-1:0] RW0_addr;
    logic                  RW0_en;
    logic                  RW0_wmode;
    logic [LANES-1:0]      RW0_wmask;
    logic [DATA_WIDTH-1:0] RW0_wdata;
    logic [DATA_WIDTH-1:0] RW0_rdata;
    logic                  RW0_rvalid;
    logic                  RW0_ready;

    modport master (
        output RW0_addr, RW0_en, RW0_wmode, RW0_wmask, RW0_wdata,
        input  RW0_rdata, RW0_rvalid, RW0_ready
    );

    modport slave (
        input  RW0_addr, RW0_en, RW0_wmode, RW0_wmask, RW0_wdata,
        output RW0_rdata, RW0_rvalid, RW0_ready
    );
endinterface

// File: rtl/sram_rw_masked_ext.sv
// rtl/sram_rw_masked_ext.sv - single-port RW SRAM with lane write mask, optional output register, clear-after-reset
module sram_rw_masked_ext #(
    parameter int ADDR_WIDTH     = 10,
    parameter int DEPTH          = 1024,
    parameter int DATA_WIDTH     = 64,
    parameter int MASK_GRAN      = 8,
    parameter bit OUT_REG        = 1'b0,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input logic                RW0_clk,
    input logic                reset,
    sram_rw_masked_ext_if.slave rw0
);
    localparam int LANES = DATA_WIDTH / MASK_GRAN;

    typedef enum logic {S_CLEAR, S_READY} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  in_range;
    logic                  acc, rd_acc, wr_acc;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [LANES-1:0]      mem_lanes;

    logic [DATA_WIDTH-1:0] raw_q;
    logic                  oob_q;
    logic                  v1_q;
    logic [DATA_WIDTH-1:0] stage1_data;

    assign in_range = {1'b0, rw0.RW0_addr} < (ADDR_WIDTH+1)'(DEPTH);
    assign acc      = (state_q == S_READY) && rw0.RW0_en;
    assign rd_acc   = acc && !rw0.RW0_wmode;
    assign wr_acc   = acc && rw0.RW0_wmode && in_range;

    // The clear sweep and user writes share the single write port.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        mem_we    = 1'b0;
        mem_waddr = rw0.RW0_addr;
        mem_wdata = rw0.RW0_wdata;
        mem_lanes = rw0.RW0_wmask;
        if (state_q == S_CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = clr_cnt_q;
            mem_wdata = '0;
            mem_lanes = '1;
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
                state_d = S_READY;
            end
        end else if (wr_acc) begin
            mem_we = 1'b1;
        end
        if (reset) begin
            mem_we = 1'b0;
        end
    end

    always_ff @(posedge RW0_clk) begin
        if (reset) begin
            state_q   <= CLEAR_ON_RESET ? S_CLEAR : S_READY;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    always_ff @(posedge RW0_clk) begin
        if (mem_we) begin
            for (int i = 0; i < LANES; i++) begin
                if (mem_lanes[i]) begin
                    mem[mem_waddr][i*MASK_GRAN +: MASK_GRAN] <= mem_wdata[i*MASK_GRAN +: MASK_GRAN];
                end
            end
        end
    end

    // Out-of-range flag travels with the read so the zero mux lines up with the data.
    always_ff @(posedge RW0_clk) begin
        if (reset) begin
            raw_q <= '0;
            oob_q <= 1'b0;
            v1_q  <= 1'b0;
        end else begin
            v1_q <= rd_acc;
            if (rd_acc) begin
                oob_q <= !in_range;
                if (in_range) begin
                    raw_q <= mem[rw0.RW0_addr];
                end
            end
        end
    end

    assign stage1_data = oob_q ? '0 : raw_q;

    generate
        if (OUT_REG) begin : g_out_reg
            logic [DATA_WIDTH-1:0] rdata_q;
            logic                  rvalid_q;
            always_ff @(posedge RW0_clk) begin
                if (reset) begin
                    rdata_q  <= '0;
                    rvalid_q <= 1'b0;
                end else begin
                    rvalid_q <= v1_q;
                    if (v1_q) begin
                        rdata_q <= stage1_data;
                    end
                end
            end
            assign rw0.RW0_rdata  = rdata_q;
            assign rw0.RW0_rvalid = rvalid_q;
        end else begin : g_no_out_reg
            assign rw0.RW0_rdata  = stage1_data;
            assign rw0.RW0_rvalid = v1_q;
        end
    endgenerate

    assign rw0.RW0_ready = (state_q == S_READY);
endmodule

// File: tb/tb_sram_rw_masked_ext.sv
// tb/tb_sram_rw_masked_ext.sv - directed bench: 1024-deep latency-1 (a), latency-2 (b), 600-deep (c)
module tb_sram_rw_masked_ext;
    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  addr;
    logic        en, wmode;
    logic [7:0]  wmask;
    logic [63:0] wdata;

    always #5 clk = ~clk;

    sram_rw_masked_ext_if #(.ADDR_WIDTH(10), .DATA_WIDTH(64), .MASK_GRAN(8)) if_a ();
    sram_rw_masked_ext_if #(.ADDR_WIDTH(10), .DATA_WIDTH(64), .MASK_GRAN(8)) if_b ();
    sram_rw_masked_ext_if #(.ADDR_WIDTH(10), .DATA_WIDTH(64), .MASK_GRAN(8)) if_c ();

    assign if_a.RW0_addr  = addr;  assign if_b.RW0_addr  = addr;  assign if_c.RW0_addr  = addr;
    assign if_a.RW0_en    = en;    assign if_b.RW0_en    = en;    assign if_c.RW0_en    = en;
    assign if_a.RW0_wmode = wmode; assign if_b.RW0_wmode = wmode; assign if_c.RW0_wmode = wmode;
    assign if_a.RW0_wmask = wmask; assign if_b.RW0_wmask = wmask; assign if_c.RW0_wmask = wmask;
    assign if_a.RW0_wdata = wdata; assign if_b.RW0_wdata = wdata; assign if_c.RW0_wdata = wdata;

    sram_rw_masked_ext #(.ADDR_WIDTH(10), .DEPTH(1024), .DATA_WIDTH(64), .MASK_GRAN(8),
                         .OUT_REG(1'b0), .CLEAR_ON_RESET(1'b1))
        u_a (.RW0_clk(clk), .reset(rst), .rw0(if_a.slave));
    sram_rw_masked_ext #(.ADDR_WIDTH(10), .DEPTH(1024), .DATA_WIDTH(64), .MASK_GRAN(8),
                         .OUT_REG(1'b1), .CLEAR_ON_RESET(1'b1))
        u_b (.RW0_clk(clk), .reset(rst), .rw0(if_b.slave));
    sram_rw_masked_ext #(.ADDR_WIDTH(10), .DEPTH(600), .DATA_WIDTH(64), .MASK_GRAN(8),
                         .OUT_REG(1'b0), .CLEAR_ON_RESET(1'b1))
        u_c (.RW0_clk(clk), .reset(rst), .rw0(if_c.slave));

    int errs   = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [9:0] a);
        en = 1'b1; wmode = 1'b0; addr = a;
        tick();
        en = 1'b0;
    endtask

    task automatic wr(input logic [9:0] a, input logic [63:0] d, input logic [7:0] m);
        en = 1'b1; wmode = 1'b1; addr = a; wdata = d; wmask = m;
        tick();
        en = 1'b0;
    endtask

    localparam logic [63:0] D1 = 64'h1111_0000_0000_0001;
    localparam logic [63:0] D2 = 64'h2222_0000_0000_0002;
    localparam logic [63:0] D3 = 64'h3333_0000_0000_0003;

    initial begin
        int n, nc, rv_cnt;
        rst = 1'b1; en = 1'b0; wmode = 1'b0; addr = '0; wmask = '0; wdata = '0;
        tick();
        check("rst_ready_a", 64'(if_a.RW0_ready), 64'd0);
        check("rst_rvalid_a", 64'(if_a.RW0_rvalid), 64'd0);
        check("rst_rdata_b", if_b.RW0_rdata, 64'd0);
        rst = 1'b0;

        // Clear sweep with a write then a read request injected early; both must be dropped.
        n = 0; nc = -1; rv_cnt = 0;
        while (!if_a.RW0_ready && n < 3000) begin
            if (n == 10) begin en = 1'b1; wmode = 1'b1; addr = 10'd5; wdata = '1; wmask = '1; end
            if (n == 20) wmode = 1'b0;
            if (n == 30) en = 1'b0;
            tick();
            n++;
            if (if_a.RW0_rvalid || if_b.RW0_rvalid || if_c.RW0_rvalid) rv_cnt++;
            if (if_c.RW0_ready && nc < 0) nc = n;
        end
        check("clear_latency_a", 64'(n), 64'd1024);
        check("clear_latency_c", 64'(nc), 64'd600);
        check("clear_no_rvalid", 64'(rv_cnt), 64'd0);
        check("ready_b", 64'(if_b.RW0_ready), 64'd1);

        rd(10'h3FF);
        check("rd3ff_rvalid_a", 64'(if_a.RW0_rvalid), 64'd1);
        check("rd3ff_rdata_a", if_a.RW0_rdata, 64'd0);
        check("rd3ff_rvalid_b_early", 64'(if_b.RW0_rvalid), 64'd0);
        check("rd3ff_oob_c", {63'd0, if_c.RW0_rvalid} | (if_c.RW0_rdata << 1), 64'd1);
        tick();
        check("rd3ff_rvalid_b", 64'(if_b.RW0_rvalid), 64'd1);
        check("rd3ff_rvalid_a_pulse", 64'(if_a.RW0_rvalid), 64'd0);

        rd(10'd5);
        check("dropped_write_a", if_a.RW0_rdata, 64'd0);
        tick();

        wr(10'd5, 64'h1122_3344_5566_7788, 8'hFF);
        check("write_no_rvalid_a", 64'(if_a.RW0_rvalid), 64'd0);
        wr(10'd5, 64'h0000_0000_0000_00AA, 8'h01);
        rd(10'd5);
        check("mask01_a", if_a.RW0_rdata, 64'h1122_3344_5566_77AA);
        tick();
        check("mask01_b", if_b.RW0_rdata, 64'h1122_3344_5566_77AA);
        wr(10'd5, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00);
        wr(10'd5, 64'h0000_BB00_0000_0000, 8'h20);
        rd(10'd5);
        check("mask00_20_a", if_a.RW0_rdata, 64'h1122_BB44_5566_77AA);

        wr(10'd7, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF);
        rd(10'd7);
        check("raw_next_cycle_a", if_a.RW0_rdata, 64'hDEAD_BEEF_CAFE_F00D);
        tick();

        wr(10'd1, D1, 8'hFF); wr(10'd2, D2, 8'hFF); wr(10'd3, D3, 8'hFF);
        en = 1'b1; wmode = 1'b0; addr = 10'd1;
        tick();
        check("pipe0_rvalid_b", 64'(if_b.RW0_rvalid), 64'd0);
        check("pipe0_a", if_a.RW0_rdata, D1);
        addr = 10'd2;
        tick();
        check("pipe1_b", {if_b.RW0_rdata[62:0], if_b.RW0_rvalid}, {D1[62:0], 1'b1});
        check("pipe1_a", if_a.RW0_rdata, D2);
        addr = 10'd3;
        tick();
        check("pipe2_b", {if_b.RW0_rdata[62:0], if_b.RW0_rvalid}, {D2[62:0], 1'b1});
        check("pipe2_a", if_a.RW0_rdata, D3);
        wmode = 1'b1; addr = 10'd9; wdata = 64'h5555; wmask = 8'hFF;
        tick();
        check("pipe3_b", {if_b.RW0_rdata[62:0], if_b.RW0_rvalid}, {D3[62:0], 1'b1});
        check("pipe3_write_a", {if_a.RW0_rdata[62:0], if_a.RW0_rvalid}, {D3[62:0], 1'b0});
        en = 1'b0;
        tick();
        check("pipe4_hold_b", {if_b.RW0_rdata[62:0], if_b.RW0_rvalid}, {D3[62:0], 1'b0});

        wr(10'd700, 64'h7007_0000_0000_0700, 8'hFF);
        wr(10'd599, 64'h5995_0000_0000_0599, 8'hFF);
        rd(10'd700);
        check("oob700_c", {if_c.RW0_rdata[62:0], if_c.RW0_rvalid}, {63'd0, 1'b1});
        check("inrange700_a", if_a.RW0_rdata, 64'h7007_0000_0000_0700);
        rd(10'd599);
        check("last599_c", if_c.RW0_rdata, 64'h5995_0000_0000_0599);
        tick();

        en = 1'b1; wmode = 1'b0; addr = 10'd5;
        tick();
        en = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_inflight_b", {if_b.RW0_rdata[62:0], if_b.RW0_rvalid}, 64'd0);
        check("rst_ready_low_a", 64'(if_a.RW0_ready), 64'd0);
        rv_cnt = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (if_a.RW0_rvalid || if_b.RW0_rvalid || if_c.RW0_rvalid) rv_cnt++;
        end
        check("rst_no_rvalid", 64'(rv_cnt), 64'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n = 0;
        while (!if_a.RW0_ready && n < 3000) begin
            tick();
            n++;
        end
        check("restart_latency_a", 64'(n), 64'd1024);
        rd(10'd5);
        check("cleared5_a", if_a.RW0_rdata, 64'd0);
        rd(10'd700);
        check("cleared700_a", if_a.RW0_rdata, 64'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
